fir_decim_round_sat: RTL

//  Output stage directly downstream of the 16-tap FIR low-pass filter.

---
 rtl/fir_pkg.sv | 18 +
 rtl/round_sat_shift.sv | 42 ++++
 rtl/fir_decim_round_sat.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared widths and types for the FIR low-pass chain and its decimating output stage.
package fir_pkg;

  localparam int FIR_IN_W       = 14;
  localparam int FIR_OUT_W      = FIR_IN_W + 16;
  localparam int DEC_OUT_W      = 16;
  localparam int DEC_MAX_LOG2   = 5;
  localparam int FIR_GAIN_SHIFT = 15;

  typedef logic signed [FIR_OUT_W-1:0] fir_out_t;
  typedef logic signed [DEC_OUT_W-1:0] dec_out_t;

  // Limit a requested decimation exponent to the largest supported one.
  function automatic logic [2:0] clamp_log2(input logic [2:0] req, input logic [2:0] max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

endpackage

// File: rtl/round_sat_shift.sv
// Combinational round-half-up arithmetic right shift followed by saturation to OUT_W bits.
module round_sat_shift #(
  parameter int SUM_W = 35,
  parameter int OUT_W = 16,
  parameter int SH_W  = 5
) (
  input  logic signed [SUM_W-1:0] sum,
  input  logic        [SH_W-1:0]  shift,
  output logic signed [OUT_W-1:0] q,
  output logic                    sat_hit
);

  // One guard bit keeps the rounding offset from wrapping a near-full-scale sum.
  localparam logic signed [SUM_W:0] MAX_V = (SUM_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [SUM_W:0] MIN_V = ~MAX_V;

  logic signed [SUM_W:0] ext;
  logic signed [SUM_W:0] half;
  logic signed [SUM_W:0] rnd;
  logic signed [SUM_W:0] shr;

  // Add half an LSB of the result, shift arithmetically, then clip to the output range.
  always_comb begin
    ext  = {sum[SUM_W-1], sum};
    half = '0;
    if (shift != '0) begin
      half = (SUM_W+1)'(1) << (shift - SH_W'(1));
    end
    rnd     = ext + half;
    shr     = rnd >>> shift;
    sat_hit = 1'b0;
    q       = shr[OUT_W-1:0];
    if (shr > MAX_V) begin
      q       = MAX_V[OUT_W-1:0];
      sat_hit = 1'b1;
    end else if (shr < MIN_V) begin
      q       = MIN_V[OUT_W-1:0];
      sat_hit = 1'b1;
    end
  end

endmodule

// File: rtl/fir_decim_round_sat.sv
// Integrate-and-dump decimator after the FIR: averages 2^dec_log2 samples, removes the
// FIR DC gain, rounds and saturates to OUT_W, and hands words out over valid/ready.
module fir_decim_round_sat
  import fir_pkg::*;
#(
  parameter int IN_W       = FIR_OUT_W,
  parameter int OUT_W      = DEC_OUT_W,
  parameter int MAX_LOG2   = DEC_MAX_LOG2,
  parameter int GAIN_SHIFT = FIR_GAIN_SHIFT
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic signed [IN_W-1:0]  din,
  input  logic                    din_en,
  input  logic        [2:0]       dec_log2,
  input  logic                    clr,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    sat,
  output logic                    overrun
);

  localparam int ACC_W = IN_W + MAX_LOG2;
  localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
  localparam int SH_W  = $clog2(MAX_LOG2 + GAIN_SHIFT + 1);

  logic signed [ACC_W-1:0] acc_reg, acc_next, sum;
  logic        [CNT_W-1:0] cnt_reg, cnt_next, last_idx;
  logic        [CNT_W:0]   span;
  logic        [2:0]       cur_log2_reg, cur_log2_next, eff_log2;
  logic        [SH_W-1:0]  shift_amt;
  logic                    frame_done;
  logic signed [OUT_W-1:0] q;
  logic                    q_sat;
  logic signed [OUT_W-1:0] dout_reg, dout_next;
  logic                    dout_valid_reg, dout_valid_next;
  logic                    sat_reg, sat_next;
  logic                    overrun_reg, overrun_next;

  // Frame length is taken from dec_log2 only on the first sample of a frame (cnt==0),
  // so a one-sample frame uses the freshly latched exponent in the same cycle.
  always_comb begin
    eff_log2   = (cnt_reg == '0) ? clamp_log2(dec_log2, 3'(MAX_LOG2)) : cur_log2_reg;
    span       = (CNT_W+1)'(1) << eff_log2;
    last_idx   = CNT_W'(span - (CNT_W+1)'(1));
    frame_done = din_en && (cnt_reg == last_idx);
    sum        = acc_reg + $signed({{MAX_LOG2{din[IN_W-1]}}, din});
    shift_amt  = SH_W'(eff_log2) + SH_W'(GAIN_SHIFT);
  end

  round_sat_shift #(
    .SUM_W (ACC_W),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) u_round_sat_shift (
    .sum     (sum),
    .shift   (shift_amt),
    .q       (q),
    .sat_hit (q_sat)
  );

  // Next-state for the accumulate/count frame logic and the output handshake register.
  always_comb begin
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    cur_log2_next   = cur_log2_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    sat_next        = sat_reg;
    overrun_next    = overrun_reg;
    if (clr) begin
      // Clear wins over sample and completion; a word finishing now is dropped.
      acc_next        = '0;
      cnt_next        = '0;
      dout_valid_next = 1'b0;
      sat_next        = 1'b0;
      overrun_next    = 1'b0;
    end else begin
      if (din_en) begin
        cur_log2_next = eff_log2;
        if (frame_done) begin
          acc_next = '0;
          cnt_next = '0;
        end else begin
          acc_next = sum;
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      if (frame_done) begin
        // Latest word wins; it only counts as overrun if the old one was not taken now.
        dout_next       = q;
        dout_valid_next = 1'b1;
        sat_next        = sat_reg | q_sat;
        overrun_next    = overrun_reg | (dout_valid_reg & ~dout_ready);
      end else if (dout_valid_reg && dout_ready) begin
        dout_valid_next = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      cur_log2_reg   <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      sat_reg        <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      cur_log2_reg   <= cur_log2_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      sat_reg        <= sat_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign sat        = sat_reg;
  assign overrun    = overrun_reg;

endmodule
